apb_sys_ctrl: RTL

// - APB completer answering the cpu master's SYSTEM accesses. The master's trap path reads

---
 rtl/apb_sys_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/apb_sys_ctrl.sv
// APB completer for cpu SYSTEM accesses: trap vector swap, prescaled 32-bit timer, irq status.
// Timer/MTIME/MTIMECMP/pend exist only when SYSCTRL_TIMER_EN is defined.
module apb_sys_ctrl #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          WAIT_STATES  = 0,
  parameter int          PRESCALE     = 1,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic                  clk,
  input  logic                  rts_n,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  interrupt
);
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_VECTOR   = 3'd1;
  localparam logic [2:0] OFF_MTIME    = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [3:0] WS           = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wcnt;
  logic        r_ien;
  logic [31:0] r_vector;
  logic        w_access, w_err, w_wr, w_wr_ctrl, w_wr_vector;
  logic        w_ten, w_pend;
  logic [2:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  assign w_off         = APB_paddr[4:2];
  assign w_unused_addr = ^APB_paddr[ADDR_WIDTH-1:5];

  // The first penable cycle (still in SETUP) already counts as an access cycle, so a
  // zero-wait transfer completes in the second bus cycle.
  assign w_access   = APB_psel && APB_penable && (r_state == SETUP || r_state == ACCESS);
  assign APB_pready = w_access && (r_wcnt == WS);
  assign w_wr       = APB_pready && APB_pwrite && !w_err;
  assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL) && APB_pstb[0];
  assign w_wr_vector = w_wr && (w_off == OFF_VECTOR);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: w_state_nxt gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (APB_psel && !APB_penable) w_state_nxt = SETUP;
      SETUP: begin
        if (!APB_psel)        w_state_nxt = IDLE;
        else if (APB_penable) w_state_nxt = APB_pready ? IDLE : ACCESS;
      end
      ACCESS: if (APB_pready || !w_access) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n)                      r_wcnt <= '0;
    else if (w_access && !APB_pready) r_wcnt <= r_wcnt + 4'd1;
    else if (r_state == IDLE)         r_wcnt <= '0;
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      r_ien    <= 1'b0;
      r_vector <= RESET_VECTOR;
    end else begin
      if (w_wr_ctrl)   r_ien    <= APB_pdata[1];
      if (w_wr_vector) r_vector <= merge_bytes(r_vector, APB_pdata, APB_pstb);
    end
  end

`ifdef SYSCTRL_TIMER_EN
  localparam logic [31:0] PS_MAX = 32'(PRESCALE - 1);

  logic        r_ten, r_pend;
  logic [31:0] r_presc, r_mtime, r_mtimecmp;
  logic        w_match, w_wr_mtime, w_wr_mtimecmp, w_clr_pend;

  assign w_match       = r_ten && (r_mtime == r_mtimecmp);
  assign w_wr_mtime    = w_wr && (w_off == OFF_MTIME) && (|APB_pstb);
  assign w_wr_mtimecmp = w_wr && (w_off == OFF_MTIMECMP);
  assign w_clr_pend    = w_wr_vector ||
                         (w_wr && (w_off == OFF_STATUS) && APB_pstb[0] && APB_pdata[0]);

  // A bus write to MTIME is placed last so it overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      r_ten      <= 1'b0;
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ten <= APB_pdata[0];
      if (r_ten) begin
        if (r_presc == PS_MAX) begin
          r_presc <= '0;
          r_mtime <= r_mtime + 32'd1;
        end else begin
          r_presc <= r_presc + 32'd1;
        end
      end
      if (w_wr_mtime)    r_mtime    <= merge_bytes(r_mtime, APB_pdata, APB_pstb);
      if (w_wr_mtimecmp) r_mtimecmp <= merge_bytes(r_mtimecmp, APB_pdata, APB_pstb);
      if (w_match)         r_pend <= 1'b1;
      else if (w_clr_pend) r_pend <= 1'b0;
    end
  end

  assign w_ten  = r_ten;
  assign w_pend = r_pend;
`else
  localparam int unused_prescale = PRESCALE;
  assign w_ten  = 1'b0;
  assign w_pend = 1'b0;
`endif

  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (APB_paddr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end else begin
      case (w_off)
        OFF_CTRL:     w_rdata = {30'd0, r_ien, w_ten};
        OFF_VECTOR:   w_rdata = r_vector;
`ifdef SYSCTRL_TIMER_EN
        OFF_MTIME:    w_rdata = r_mtime;
        OFF_MTIMECMP: w_rdata = r_mtimecmp;
`endif
        OFF_STATUS:   w_rdata = {31'd0, w_pend};
        default:      w_err   = 1'b1;
      endcase
    end
  end

  assign APB_perr   = APB_pready && w_err;
  assign APB_prdata = (w_access && !w_err) ? w_rdata : '0;
  assign interrupt  = w_pend && r_ien;
endmodule
